// File: rtl/reg_bridge.sv
// reg_bridge: host request/response to core register strobe bridge with a local irq status register.
// Ports: clk/reset (async, active-high); req_* host request channel; rsp_* host response channel;
// data_in/write_en/read_en/data_out core register side; irq_in core interrupt level; irq host interrupt.
// Build option: define REG_BRIDGE_ERR_EN to flag unmapped accesses with rsp_err.
module reg_bridge #(
  parameter int REGS   = 3,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       data_in,
  input  logic [31:0]       data_out [REGS],
  output logic              write_en [REGS],
  output logic              read_en  [REGS],
  input  logic              irq_in,
  output logic              irq
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [ADDR_W-1:0] LOCAL = '1;
  logic [1:0]        state;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              irq_prev;
  logic              irq_pending;
  logic              local_hit;
  logic              clr;
  logic              rise;
  logic [31:0]       rd_mux;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign data_in   = state == ACCESS ? wdata : '0;
  assign local_hit = addr == LOCAL;
  assign irq       = irq_pending;
  assign rise      = irq_in & ~irq_prev;
  assign clr       = state == ACCESS && wr && local_hit && wdata[0];
  // Strobes are decoded combinationally from state so an async reset drops them at once.
  always_comb begin
    rd_mux = local_hit ? {31'b0, irq_pending} : '0;
    for (int i = 0; i < REGS; i++) begin
      write_en[i] = state == ACCESS && wr && addr == ADDR_W'(i);
      read_en[i]  = state == ACCESS && !wr && addr == ADDR_W'(i);
      if (addr == ADDR_W'(i)) rd_mux = data_out[i];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr          <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      rsp_rdata   <= '0;
      irq_prev    <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_prev    <= irq_in;
      irq_pending <= rise | (irq_pending & ~clr);
      if (state == IDLE && req_valid) begin
        wr    <= req_write;
        addr  <= req_addr;
        wdata <= req_wdata;
        state <= ACCESS;
      end else if (state == ACCESS) begin
        rsp_rdata <= wr ? '0 : rd_mux;
        state     <= RESP;
      end else if (state == RESP && rsp_ready) begin
        state <= IDLE;
      end
    end
  end
`ifdef REG_BRIDGE_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_err <= 1'b0;
    else if (state == ACCESS) rsp_err <= addr >= ADDR_W'(REGS) && !local_hit;
  end
`else
  assign rsp_err = 1'b0;
`endif
endmodule
